// File: rtl/astar_expand_ctrl.sv
// A* neighbor-expansion sequencer: walks N/E/S/W of the current node, queries the
// closed list for each in-grid neighbor and pushes non-closed ones to the open list.
module astar_expand_ctrl #(
    parameter int unsigned GRID_W  = 20,
    parameter int unsigned GRID_H  = 20,
    parameter int unsigned COORD_W = 8,
    parameter int unsigned COST_W  = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  logic [COST_W-1:0]  cur_g,
    output logic               busy,
    output logic               done,
    output logic [2:0]         ins_count,
    output logic               search_req,
    output logic [COORD_W-1:0] search_x,
    output logic [COORD_W-1:0] search_y,
    input  logic               search_done,
    input  logic               search_found,
    output logic               ins_valid,
    input  logic               ins_ready,
    output logic [COORD_W-1:0] ins_x,
    output logic [COORD_W-1:0] ins_y,
    output logic [COST_W-1:0]  ins_g,
    output logic [1:0]         ins_dir
);

    typedef enum logic [2:0] {StIdle, StCheck, StSearch, StInsert, StDone} state_e;

    localparam logic [COORD_W-1:0] MaxX     = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] MaxY     = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] CoordOne = COORD_W'(1);
    localparam logic [2:0]         DirEnd   = 3'd4;

    state_e state_q, state_d;

    logic [COORD_W-1:0] cur_x_q, cur_x_d;
    logic [COORD_W-1:0] cur_y_q, cur_y_d;
    logic [COST_W-1:0]  cur_g_q, cur_g_d;
    logic [2:0]         dir_q, dir_d;
    logic [2:0]         count_q, count_d;
    logic [COORD_W-1:0] search_x_q, search_x_d;
    logic [COORD_W-1:0] search_y_q, search_y_d;
    logic [COORD_W-1:0] ins_x_q, ins_x_d;
    logic [COORD_W-1:0] ins_y_q, ins_y_d;
    logic [COST_W-1:0]  ins_g_q, ins_g_d;
    logic [1:0]         ins_dir_q, ins_dir_d;

    logic [COORD_W-1:0] nb_x;
    logic [COORD_W-1:0] nb_y;
    logic               nb_oob;
    logic [COST_W:0]    g_sum;
    logic [COST_W-1:0]  g_inc;

    // Neighbor of the current node in direction dir_q; bounds tested before any arithmetic wraps.
    always_comb begin
        nb_x   = cur_x_q;
        nb_y   = cur_y_q;
        nb_oob = 1'b0;
        unique case (dir_q[1:0])
            2'd0: begin
                nb_y   = cur_y_q - CoordOne;
                nb_oob = (cur_y_q == '0);
            end
            2'd1: begin
                nb_x   = cur_x_q + CoordOne;
                nb_oob = (cur_x_q == MaxX);
            end
            2'd2: begin
                nb_y   = cur_y_q + CoordOne;
                nb_oob = (cur_y_q == MaxY);
            end
            2'd3: begin
                nb_x   = cur_x_q - CoordOne;
                nb_oob = (cur_x_q == '0);
            end
        endcase
    end

    assign g_sum = {1'b0, cur_g_q} + (COST_W + 1)'(1);
    assign g_inc = g_sum[COST_W] ? '1 : g_sum[COST_W-1:0];

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StCheck;
            end
            StCheck: begin
                if (dir_q == DirEnd) begin
                    state_d = StDone;
                end else if (!nb_oob) begin
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (search_done) state_d = search_found ? StCheck : StInsert;
            end
            StInsert: begin
                if (ins_ready) state_d = StCheck;
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output decode
    always_comb begin
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);
        search_req = (state_q == StSearch);
        ins_valid  = (state_q == StInsert);
    end

    // Datapath next-state
    always_comb begin
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        cur_g_d    = cur_g_q;
        dir_d      = dir_q;
        count_d    = count_q;
        search_x_d = search_x_q;
        search_y_d = search_y_q;
        ins_x_d    = ins_x_q;
        ins_y_d    = ins_y_q;
        ins_g_d    = ins_g_q;
        ins_dir_d  = ins_dir_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cur_x_d = cur_x;
                    cur_y_d = cur_y;
                    cur_g_d = cur_g;
                    dir_d   = '0;
                    count_d = '0;
                end
            end
            StCheck: begin
                if (dir_q != DirEnd) begin
                    if (nb_oob) begin
                        dir_d = dir_q + 3'd1;
                    end else begin
                        search_x_d = nb_x;
                        search_y_d = nb_y;
                    end
                end
            end
            StSearch: begin
                if (search_done) begin
                    if (search_found) begin
                        dir_d = dir_q + 3'd1;
                    end else begin
                        ins_x_d   = search_x_q;
                        ins_y_d   = search_y_q;
                        ins_g_d   = g_inc;
                        ins_dir_d = dir_q[1:0];
                    end
                end
            end
            StInsert: begin
                if (ins_ready) begin
                    count_d = count_q + 3'd1;
                    dir_d   = dir_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            cur_g_q    <= '0;
            dir_q      <= '0;
            count_q    <= '0;
            search_x_q <= '0;
            search_y_q <= '0;
            ins_x_q    <= '0;
            ins_y_q    <= '0;
            ins_g_q    <= '0;
            ins_dir_q  <= '0;
        end else begin
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            cur_g_q    <= cur_g_d;
            dir_q      <= dir_d;
            count_q    <= count_d;
            search_x_q <= search_x_d;
            search_y_q <= search_y_d;
            ins_x_q    <= ins_x_d;
            ins_y_q    <= ins_y_d;
            ins_g_q    <= ins_g_d;
            ins_dir_q  <= ins_dir_d;
        end
    end

    assign ins_count = count_q;
    assign search_x  = search_x_q;
    assign search_y  = search_y_q;
    assign ins_x     = ins_x_q;
    assign ins_y     = ins_y_q;
    assign ins_g     = ins_g_q;
    assign ins_dir   = ins_dir_q;

endmodule

// File: tb/tb_astar_expand_ctrl.sv
// Bench for astar_expand_ctrl: directed and random expansions checked against a
// neighbor-list reference model, with a responsive closed-list engine and open-list sink.
`timescale 1ns/1ps
module tb_astar_expand_ctrl;

    localparam int GW = 20;
    localparam int GH = 20;
    localparam int GMAX = 1023;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cur_x = '0;
    logic [7:0] cur_y = '0;
    logic [9:0] cur_g = '0;
    logic       busy, done, search_req, ins_valid;
    logic [2:0] ins_count;
    logic [7:0] search_x, search_y, ins_x, ins_y;
    logic [9:0] ins_g;
    logic [1:0] ins_dir;
    logic       search_done = 1'b0;
    logic       search_found = 1'b0;
    logic       ins_ready = 1'b0;

    astar_expand_ctrl #(
        .GRID_W (GW),
        .GRID_H (GH),
        .COORD_W(8),
        .COST_W (10)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .cur_g       (cur_g),
        .busy        (busy),
        .done        (done),
        .ins_count   (ins_count),
        .search_req  (search_req),
        .search_x    (search_x),
        .search_y    (search_y),
        .search_done (search_done),
        .search_found(search_found),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_x       (ins_x),
        .ins_y       (ins_y),
        .ins_g       (ins_g),
        .ins_dir     (ins_dir)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Closed-list contents: 0 = empty, 1 = everything closed, 2 = hashed pattern
    int cmode = 0;
    int cseed = 0;

    int exp_sx[$], exp_sy[$], exp_ix[$], exp_iy[$], exp_ig[$], exp_id[$];
    int obs_sx[$], obs_sy[$], obs_ix[$], obs_iy[$], obs_ig[$], obs_id[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_closed(input int x, input int y);
        if (cmode == 0) return 1'b0;
        if (cmode == 1) return 1'b1;
        return ((x * 31 + y * 17 + cseed) % 3) == 0;
    endfunction

    // Expected search and insert sequences from the neighbor rules.
    task automatic build_model(input int cx, input int cy, input int cg);
        int dx[4];
        int dy[4];
        dx = '{0, 1, 0, -1};
        dy = '{-1, 0, 1, 0};
        exp_sx.delete(); exp_sy.delete();
        exp_ix.delete(); exp_iy.delete(); exp_ig.delete(); exp_id.delete();
        for (int d = 0; d < 4; d++) begin
            int nx, ny;
            nx = cx + dx[d];
            ny = cy + dy[d];
            if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) begin
                exp_sx.push_back(nx);
                exp_sy.push_back(ny);
                if (!is_closed(nx, ny)) begin
                    exp_ix.push_back(nx);
                    exp_iy.push_back(ny);
                    exp_ig.push_back((cg + 1 > GMAX) ? GMAX : cg + 1);
                    exp_id.push_back(d);
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({busy, done, search_req, ins_valid, ins_count, search_x, search_y,
                      ins_x, ins_y, ins_g, ins_dir}), 64'd0);
    endtask

    // One expansion with responsive engine/sink. first_stall < 0 means random stall.
    task automatic run_exp(input int cx, input int cy, input int cg, input int mode,
                           input int seed, input int max_sdly, input int max_stall,
                           input int first_stall, input bit stray, input bit abort2);
        int cyc, acc, done_cyc, n_sreq, s_wait, stall, sx, sy, cnt_done;
        bit s_act, i_act, aborted;
        int hx, hy, hg, hd;
        cmode = mode;
        cseed = seed;
        build_model(cx, cy, cg);
        obs_sx.delete(); obs_sy.delete();
        obs_ix.delete(); obs_iy.delete(); obs_ig.delete(); obs_id.delete();
        @(negedge Clk);
        start = 1'b1;
        cur_x = 8'(cx);
        cur_y = 8'(cy);
        cur_g = 10'(cg);
        @(posedge Clk);
        cyc = 0; acc = 0; done_cyc = -1; n_sreq = 0; s_wait = 0; stall = 0;
        sx = 0; sy = 0; cnt_done = 0; hx = 0; hy = 0; hg = 0; hd = 0;
        s_act = 0; i_act = 0; aborted = 0;
        while (cyc < 300) begin
            @(negedge Clk);
            search_done = 1'b0;
            ins_ready = 1'b0;
            start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                cnt_done = int'(ins_count);
                break;
            end
            chk("busy_run", 64'(busy), 64'd1);
            if (stray && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
                cur_x = 8'($urandom_range(0, 19));
                cur_y = 8'($urandom_range(0, 19));
                cur_g = 10'($urandom_range(0, 1023));
            end
            if (search_req) begin
                if (!s_act) begin
                    s_act = 1;
                    sx = int'(search_x);
                    sy = int'(search_y);
                    obs_sx.push_back(sx);
                    obs_sy.push_back(sy);
                    s_wait = int'($urandom_range(0, max_sdly));
                    acc += s_wait + 1;
                    n_sreq++;
                    if (abort2 && n_sreq == 2) begin
                        #2 Reset = 1'b1;
                        #1 chk_all_zero("abort_outputs");
                        aborted = 1;
                        break;
                    end
                end else begin
                    chk("search_xy_stable", 64'({search_x, search_y}), 64'({8'(sx), 8'(sy)}));
                end
                if (s_wait == 0) begin
                    search_done = 1'b1;
                    search_found = is_closed(sx, sy);
                end else begin
                    s_wait--;
                end
            end else begin
                s_act = 0;
                if (stray && $urandom_range(0, 1) == 1) begin
                    search_done = 1'b1;
                    search_found = 1'($urandom_range(0, 1));
                end
            end
            if (ins_valid) begin
                if (!i_act) begin
                    i_act = 1;
                    hx = int'(ins_x); hy = int'(ins_y); hg = int'(ins_g); hd = int'(ins_dir);
                    obs_ix.push_back(hx); obs_iy.push_back(hy);
                    obs_ig.push_back(hg); obs_id.push_back(hd);
                    stall = (obs_ix.size() == 1 && first_stall >= 0) ? first_stall
                                                                     : int'($urandom_range(0, max_stall));
                    acc += stall + 1;
                end else begin
                    chk("ins_stable", 64'({ins_x, ins_y, ins_g, ins_dir}),
                        64'({8'(hx), 8'(hy), 10'(hg), 2'(hd)}));
                end
                if (stall == 0) ins_ready = 1'b1;
                else stall--;
            end else begin
                i_act = 0;
                if (stray && $urandom_range(0, 1) == 1) ins_ready = 1'b1;
            end
            @(posedge Clk);
            cyc++;
        end
        if (aborted) begin
            search_done = 1'b0;
            ins_ready = 1'b0;
            @(negedge Clk);
            chk_all_zero("abort_held");
            Reset = 1'b0;
            @(negedge Clk);
            chk("abort_no_done", 64'({busy, done, search_req, ins_valid}), 64'd0);
            return;
        end
        chk("done_seen", 64'(done_cyc >= 0), 64'd1);
        chk("done_cycle", 64'(done_cyc), 64'(5 + acc));
        chk("count_at_done", 64'(cnt_done), 64'(exp_ix.size()));
        @(negedge Clk);
        chk("done_one_cycle", 64'({busy, done, search_req, ins_valid}), 64'd0);
        chk("count_held", 64'(ins_count), 64'(exp_ix.size()));
        chk("n_search", 64'(obs_sx.size()), 64'(exp_sx.size()));
        for (int i = 0; i < exp_sx.size() && i < obs_sx.size(); i++)
            chk("search_coord", 64'({obs_sx[i], obs_sy[i]}), 64'({exp_sx[i], exp_sy[i]}));
        chk("n_insert", 64'(obs_ix.size()), 64'(exp_ix.size()));
        for (int i = 0; i < exp_ix.size() && i < obs_ix.size(); i++) begin
            chk("ins_coord", 64'({obs_ix[i], obs_iy[i]}), 64'({exp_ix[i], exp_iy[i]}));
            chk("ins_g", 64'(obs_ig[i]), 64'(exp_ig[i]));
            chk("ins_dir", 64'(obs_id[i]), 64'(exp_id[i]));
        end
    endtask

    initial begin
        // Asynchronous reset with no clock edge yet
        #3 chk_all_zero("reset_state");
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk_all_zero("post_reset_idle");

        // Interior, all closed, single-cycle searches: done in cycle 9
        run_exp(5, 5, 3, 1, 0, 0, 0, 0, 1'b0, 1'b0);
        // Corner (0,0), nothing closed
        run_exp(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        // Far corner with a 5-cycle stall on the first insert
        run_exp(19, 19, 7, 0, 0, 0, 0, 5, 1'b0, 1'b0);
        // Saturating g-cost
        run_exp(10, 10, 1023, 0, 0, 1, 1, -1, 1'b0, 1'b0);
        // Edge midpoints
        run_exp(0, 9, 100, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run_exp(19, 0, 1022, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // Reset during second search, then a clean run
        run_exp(5, 5, 3, 0, 0, 1, 0, 0, 1'b0, 1'b1);
        run_exp(5, 5, 3, 1, 0, 0, 0, 0, 1'b0, 1'b0);

        // Stray handshakes while idle must not start anything
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            search_done = 1'b1;
            search_found = 1'b0;
            ins_ready = 1'b1;
            @(negedge Clk);
            chk("idle_stray", 64'({busy, done, search_req, ins_valid}), 64'd0);
        end
        search_done = 1'b0;
        ins_ready = 1'b0;

        // Stray start/search_done/ins_ready during an expansion
        run_exp(7, 3, 12, 0, 0, 2, 2, -1, 1'b1, 1'b0);
        run_exp(7, 3, 12, 2, 5, 2, 2, -1, 1'b1, 1'b0);

        // Randomized expansions
        for (int r = 0; r < 25; r++) begin
            int rx, ry, rg;
            rx = int'($urandom_range(0, GW - 1));
            ry = int'($urandom_range(0, GH - 1));
            rg = ($urandom_range(0, 9) == 0) ? GMAX : int'($urandom_range(0, GMAX - 1));
            run_exp(rx, ry, rg, int'($urandom_range(0, 2)), int'($urandom_range(0, 99)),
                    3, 3, -1, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/astar_expand_ctrl.md
# astar_expand_ctrl

Neighbor-expansion sequencer for the A* grid search engine. Given the current node popped from the open list, it walks the four orthogonal neighbors in fixed order, skips out-of-grid cells, asks the closed-list linear search engine whether each neighbor is already closed, and pushes every non-closed neighbor into the open-list insert port with cost g+1. It sits between the open-list pop logic and the closed-list search and open-list insert datapaths, and owns the handshakes to both.

## Interface
- GRID_W, 20, grid width in cells; x ranges 0..GRID_W-1
- GRID_H, 20, grid height in cells; y ranges 0..GRID_H-1
- COORD_W, 8, coordinate width
- COST_W, 10, g-cost width
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high; all state and outputs cleared
- start  in  1  request expansion of cur_x/cur_y/cur_g; sampled only in IDLE
- cur_x, cur_y  in  COORD_W  current node; latched on accepted start
- cur_g  in  COST_W  current node g-cost; latched on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when expansion completes
- ins_count  out  3  number of neighbors inserted (0..4); valid while done is high, held until next accepted start
- search_req  out  1  level request to closed-list search engine
- search_x, search_y  out  COORD_W  neighbor being checked; stable while search_req high
- search_done  in  1  one-cycle pulse from engine: result valid
- search_found  in  1  1 = neighbor already in closed list; sampled only with search_done
- ins_valid  out  1  open-list insert request
- ins_ready  in  1  open-list accepts insert when ins_valid && ins_ready at a rising edge
- ins_x, ins_y  out  COORD_W  inserted neighbor coordinates
- ins_g  out  COST_W  cur_g+1, saturating at 2^COST_W-1
- ins_dir  out  2  direction from current node to neighbor: 0=N,1=E,2=S,3=W (parent back-pointer)

## Operation
- Reset values: busy, done, search_req, ins_valid = 0; ins_count, search_x/y, ins_x/y/g/dir = 0; state IDLE; direction counter dir = 0.
- All outputs registered or decoded from registered state; no combinational path from inputs to outputs.
- Neighbor order: N (x, y-1), E (x+1, y), S (x, y+1), W (x-1, y).
- Out-of-bounds: N skipped if y==0; E if x==GRID_W-1; S if y==GRID_H-1; W if x==0. No wrap-around; skipped cells never reach search or insert.
- States:
  - IDLE: on start, latch cur_*, clear dir and ins_count -> CHECK. Otherwise stay.
  - CHECK: if dir==4 -> DONE. Else if neighbor[dir] out of bounds: dir+1, stay CHECK. Else load search_x/y -> SEARCH.
  - SEARCH: search_req=1. On search_done: found=1 -> dir+1, CHECK; found=0 -> load ins_x/y/g/dir -> INSERT.
  - INSERT: ins_valid=1, outputs stable. On ins_ready: ins_count+1, dir+1 -> CHECK.
  - DONE: done=1 for exactly one cycle -> IDLE.
- g arithmetic: computed in COST_W+1 bits; if carry, ins_g = all ones.
- start while busy: ignored, no latch. search_done outside SEARCH: ignored. ins_ready outside INSERT: ignored.
- Reset mid-operation (any state): immediate return to IDLE with reset values; pending search/insert abandoned, no done pulse.

## Timing
- start sampled at edge 0 -> CHECK during cycle after edge 0; busy high from same edge.
- CHECK costs 1 cycle per direction (skipped or not) plus 1 final cycle at dir==4.
- search_req rises the edge after CHECK; falls the edge that samples search_done.
- ins_valid rises the edge that samples search_done with found=0; falls the edge that samples ins_ready.
- Minimum expansion, interior node, all four closed, search_done in first SEARCH cycle: done high during cycle 9 (edges numbered from start), busy low at edge 10.
- Next start accepted in the cycle after DONE (IDLE).

## Test plan
- Interior node (5,5), g=3, engine returns found=1 on first cycle for all -> 4 search_req pulses at (5,4),(6,5),(5,6),(4,5); no ins_valid; done in cycle 9; ins_count=0.
- Corner (0,0), g=0, found=0, ins_ready=1 -> searches only (1,0),(0,1); inserts (1,0,g=1,dir=1) then (0,1,g=1,dir=2); ins_count=2.
- Corner (19,19), found=0, ins_ready low 5 cycles on first insert -> ins_x/y/g/dir stable throughout stall; inserts (19,18,dir=0) then (18,19,dir=3); ins_count=2.
- cur_g=1023 at (10,10), found=0 -> all four inserts carry ins_g=1023; ins_count=4.
- Reset asserted during SEARCH of second neighbor -> all outputs 0 asynchronously, no done; fresh start afterward behaves as clean run.
- start pulsed while busy with different cur_x/cur_y, and stray search_done/ins_ready in IDLE -> ignored; original expansion coordinates and ins_count unaffected.
